sr_ctrl: RTL and testbench

SR_CTRL -- requirements
Module: sr_ctrl

---
 rtl/sr_ctrl_pkg.sv | 21 ++
 rtl/sr_pulse_timer.sv | 50 +++++
 rtl/sr_ctrl.sv | 168 ++++++++++++++++
 tb/tb_sr_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sr_ctrl_pkg
// Description : Shared types and constants for the SR flip-flop pulse
//               controller. It holds the controller state enum and the width
//               of the pulse/gap down-counter.
// Revision    : 1.0 - initial release
// ============================================================================
package sr_ctrl_pkg;

   // Width of the pulse/gap down-counter. PULSE_W and GAP_W must fit in it.
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } state_t;

endpackage : sr_ctrl_pkg
`default_nettype wire

// File: rtl/sr_pulse_timer.sv
`default_nettype none
// ============================================================================
// Module      : sr_pulse_timer
// Description : 4-bit down-counter that times the PULSE and GAP phases.
//               A load takes priority over a decrement. The count stops at
//               zero and never wraps. done_o is high while the count is 1,
//               which marks the last cycle of the current phase.
// Ports       : clk        - clock, rising edge
//               reset      - synchronous active-high reset (count -> 0)
//               load_i     - load load_val_i into the counter
//               load_val_i - value to load
//               dec_i      - decrement, ignored while the count is zero
//               done_o     - count equals 1
// Revision    : 1.0 - initial release
// ============================================================================
module sr_pulse_timer
   import sr_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             done_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == CNT_W'(1));

endmodule : sr_pulse_timer
`default_nettype wire

// File: rtl/sr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sr_ctrl
// Description : Drives the set/reset inputs of an external SR flip-flop with
//               timed pulses and keeps a model of the flip-flop state. An
//               accepted request pulses s_o (level 1) or r_o (level 0) for
//               PULSE_W cycles, then holds off for GAP_W idle cycles. A
//               request that would not change the modeled state is absorbed
//               without a pulse unless req_force_i is set.
// Parameters  : PULSE_W - pulse length in cycles (1..15)
//               GAP_W   - idle cycles after each pulse (0..15)
// Ports       : clk, reset               - clock / synchronous active-high reset
//               req_valid_i, req_ready_o - request handshake (ready only in IDLE)
//               req_level_i, req_force_i - target level / pulse regardless
//               s_o, r_o                 - registered set / reset drives
//               q_model_o                - modeled flip-flop state
//               busy_o                   - controller not in IDLE
//               q_i, err_clr_i, err_o    - readback check (SR_CTRL_CHECK_EN)
// Config      : define SR_CTRL_CHECK_EN to add the flip-flop readback check
//               and its sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_ctrl
   import sr_ctrl_pkg::*;
#(
   parameter int PULSE_W = 1,
   parameter int GAP_W   = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic req_valid_i,
   output logic req_ready_o,
   input  logic req_level_i,
   input  logic req_force_i,
`ifdef SR_CTRL_CHECK_EN
   input  logic q_i,
   input  logic err_clr_i,
   output logic err_o,
`endif
   output logic s_o,
   output logic r_o,
   output logic q_model_o,
   output logic busy_o
);

   state_t           state_q, state_d;
   logic             level_q, level_d;   // level captured at acceptance
   logic             s_q, s_d;
   logic             r_q, r_d;
   logic             q_model_q, q_model_d;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_dec;
   logic             tmr_done;

   sr_pulse_timer u_timer (
      .clk        (clk),
      .reset      (reset),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .dec_i      (tmr_dec),
      .done_o     (tmr_done)
   );

   // s_d and r_d are only ever driven from one level bit and its inverse
   // (or both zero), so the two drives can never overlap.
   always_comb begin
      state_d   = state_q;
      level_d   = level_q;
      s_d       = 1'b0;
      r_d       = 1'b0;
      q_model_d = q_model_q;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      tmr_dec   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid_i && ((req_level_i != q_model_q) || req_force_i)) begin
               state_d  = PULSE;
               level_d  = req_level_i;
               s_d      = req_level_i;
               r_d      = ~req_level_i;
               tmr_load = 1'b1;
               tmr_val  = CNT_W'(PULSE_W);
            end
         end
         PULSE: begin
            if (tmr_done) begin
               q_model_d = level_q;
               if (GAP_W == 0) begin
                  state_d = IDLE;
               end else begin
                  state_d  = GAP;
                  tmr_load = 1'b1;
                  tmr_val  = CNT_W'(GAP_W);
               end
            end else begin
               s_d     = level_q;
               r_d     = ~level_q;
               tmr_dec = 1'b1;
            end
         end
         GAP: begin
            if (tmr_done) begin
               state_d = IDLE;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         level_q   <= 1'b0;
         s_q       <= 1'b0;
         r_q       <= 1'b0;
         q_model_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         level_q   <= level_d;
         s_q       <= s_d;
         r_q       <= r_d;
         q_model_q <= q_model_d;
      end
   end

   assign req_ready_o = (state_q == IDLE);
   assign busy_o      = (state_q != IDLE);
   assign s_o         = s_q;
   assign r_o         = r_q;
   assign q_model_o   = q_model_q;

`ifdef SR_CTRL_CHECK_EN
   // chk_q is high in the first cycle after the last pulse cycle, when
   // q_model_q already holds the new level and the flip-flop should match.
   logic chk_q, chk_d;
   logic err_q, err_d;

   always_comb begin
      chk_d = (state_q == PULSE) && tmr_done;
      err_d = err_q;
      if (chk_q && (q_i != q_model_q)) begin
         err_d = 1'b1;
      end else if (err_clr_i) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         chk_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         chk_q <= chk_d;
         err_q <= err_d;
      end
   end

   assign err_o = err_q;
`endif

endmodule : sr_ctrl
`default_nettype wire

// File: tb/tb_sr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_ctrl
// Description : Self-checking bench for sr_ctrl. Three instances with
//               different PULSE_W/GAP_W share one stimulus stream. A
//               timestamp-based reference model predicts every output of
//               every instance each cycle; a vector table and hand-written
//               sequences add fixed expectations for the corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_ctrl;

   localparam int ND = 3;
   localparam int PW [ND] = '{1, 3, 4};
   localparam int GW [ND] = '{1, 2, 0};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic valid = 1'b0;
   logic level = 1'b0;
   logic frc = 1'b0;
   logic clr = 1'b0;
   logic q_tie = 1'b0;
   logic q_in  [ND];
   logic s_w   [ND];
   logic r_w   [ND];
   logic q_w   [ND];
   logic rdy_w [ND];
   logic bsy_w [ND];
`ifdef SR_CTRL_CHECK_EN
   logic err_w [ND];
`endif

   always #5 clk = ~clk;

   sr_ctrl #(.PULSE_W(1), .GAP_W(1)) u_a (
      .clk(clk), .reset(rst), .req_valid_i(valid), .req_ready_o(rdy_w[0]),
      .req_level_i(level), .req_force_i(frc),
`ifdef SR_CTRL_CHECK_EN
      .q_i(q_in[0]), .err_clr_i(clr), .err_o(err_w[0]),
`endif
      .s_o(s_w[0]), .r_o(r_w[0]), .q_model_o(q_w[0]), .busy_o(bsy_w[0]));

   sr_ctrl #(.PULSE_W(3), .GAP_W(2)) u_b (
      .clk(clk), .reset(rst), .req_valid_i(valid), .req_ready_o(rdy_w[1]),
      .req_level_i(level), .req_force_i(frc),
`ifdef SR_CTRL_CHECK_EN
      .q_i(q_in[1]), .err_clr_i(clr), .err_o(err_w[1]),
`endif
      .s_o(s_w[1]), .r_o(r_w[1]), .q_model_o(q_w[1]), .busy_o(bsy_w[1]));

   sr_ctrl #(.PULSE_W(4), .GAP_W(0)) u_c (
      .clk(clk), .reset(rst), .req_valid_i(valid), .req_ready_o(rdy_w[2]),
      .req_level_i(level), .req_force_i(frc),
`ifdef SR_CTRL_CHECK_EN
      .q_i(q_in[2]), .err_clr_i(clr), .err_o(err_w[2]),
`endif
      .s_o(s_w[2]), .r_o(r_w[2]), .q_model_o(q_w[2]), .busy_o(bsy_w[2]));

   // ---------------- reference model ----------------
   // A request accepted in cycle t pulses in cycles t+1..t+P, the new level
   // is visible from t+P+1, and the block is ready again at t+P+G+1.
   int cyc = 0;
   int acc  [ND];
   bit lvl  [ND];
   bit qold [ND];
   bit merr [ND];

   function automatic bit m_act(int k, int c);
      return (acc[k] >= 0) && (c > acc[k]) && (c <= acc[k] + PW[k] + GW[k]);
   endfunction

   function automatic bit m_pul(int k, int c);
      return (acc[k] >= 0) && (c > acc[k]) && (c <= acc[k] + PW[k]);
   endfunction

   function automatic bit m_q(int k, int c);
      if ((acc[k] >= 0) && (c > acc[k] + PW[k])) return lvl[k];
      return qold[k];
   endfunction

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string name, input int k, input logic act, input logic exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s dut%0d cycle %0d: got %b expected %b", name, k, cyc, act, exp);
   endtask

   // Advance one clock: drive readback, clock, update model, compare all.
   task automatic step(input bit corrupt);
      for (int k = 0; k < ND; k++)
         q_in[k] = q_tie ? 1'b0 : (m_q(k, cyc) ^ corrupt);
      @(posedge clk);
      for (int k = 0; k < ND; k++) begin
         if (rst) begin
            acc[k] = -1; qold[k] = 1'b0; merr[k] = 1'b0;
         end else begin
            if ((acc[k] >= 0) && (cyc == acc[k] + PW[k] + 1) && (q_in[k] != lvl[k]))
               merr[k] = 1'b1;
            else if (clr)
               merr[k] = 1'b0;
            if (!m_act(k, cyc) && valid && ((level != m_q(k, cyc)) || frc)) begin
               qold[k] = m_q(k, cyc);
               lvl[k]  = level;
               acc[k]  = cyc;
            end
         end
      end
      cyc++;
      @(negedge clk);
      for (int k = 0; k < ND; k++) begin
         chk("s_o", k, s_w[k], m_pul(k, cyc) && lvl[k]);
         chk("r_o", k, r_w[k], m_pul(k, cyc) && !lvl[k]);
         chk("q_model_o", k, q_w[k], m_q(k, cyc));
         chk("req_ready_o", k, rdy_w[k], !m_act(k, cyc));
         chk("busy_o", k, bsy_w[k], m_act(k, cyc));
         chk("s_r_exclusive", k, s_w[k] & r_w[k], 1'b0);
`ifdef SR_CTRL_CHECK_EN
         chk("err_o", k, err_w[k], merr[k]);
`endif
      end
   endtask

   task automatic drive(input bit r, input bit v, input bit l, input bit f);
      rst = r; valid = v; level = l; frc = f;
   endtask

   // ---------------- vector table for u_a (P=1, G=1) ----------------
   // Expected outputs are those seen in the cycle after the row's inputs.
   typedef struct {
      bit rst, v, l, f;
      bit s, r, q, rdy, bsy;
   } vec_t;
   vec_t tbl [11];

   initial begin
      for (int k = 0; k < ND; k++) begin
         acc[k] = -1; lvl[k] = 1'b0; qold[k] = 1'b0; merr[k] = 1'b0; q_in[k] = 1'b0;
      end
      //          rst v  l  f    s  r  q  rdy bsy
      tbl[0]  = '{1, 0, 0, 0,   0, 0, 0, 1, 0};  // reset
      tbl[1]  = '{0, 1, 1, 0,   1, 0, 0, 0, 1};  // set request accepted
      tbl[2]  = '{0, 1, 0, 0,   0, 0, 1, 0, 1};  // ignored while busy, GAP
      tbl[3]  = '{0, 0, 0, 0,   0, 0, 1, 1, 0};  // back to IDLE
      tbl[4]  = '{0, 1, 1, 0,   0, 0, 1, 1, 0};  // no change, no pulse
      tbl[5]  = '{0, 1, 1, 1,   1, 0, 1, 0, 1};  // forced pulse
      tbl[6]  = '{0, 0, 0, 0,   0, 0, 1, 0, 1};  // GAP
      tbl[7]  = '{0, 1, 0, 0,   0, 0, 1, 1, 0};  // request in GAP dropped
      tbl[8]  = '{0, 1, 0, 0,   0, 1, 1, 0, 1};  // reset request accepted
      tbl[9]  = '{0, 0, 0, 0,   0, 0, 0, 0, 1};  // GAP, model now 0
      tbl[10] = '{0, 0, 0, 0,   0, 0, 0, 1, 0};  // IDLE

      drive(1, 0, 0, 0);
      step(0);
      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].rst, tbl[i].v, tbl[i].l, tbl[i].f);
         step(0);
         chk("tbl_s", 0, s_w[0], tbl[i].s);
         chk("tbl_r", 0, r_w[0], tbl[i].r);
         chk("tbl_q", 0, q_w[0], tbl[i].q);
         chk("tbl_ready", 0, rdy_w[0], tbl[i].rdy);
         chk("tbl_busy", 0, bsy_w[0], tbl[i].bsy);
      end

      // ---- u_b (P=3, G=2): reset pulse from q_model=1 ----
      drive(1, 0, 0, 0); step(0);
      drive(0, 1, 1, 0); step(0);
      drive(0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0);
      chk("b_q_before", 1, q_w[1], 1'b1);
      chk("b_ready_before", 1, rdy_w[1], 1'b1);
      drive(0, 1, 0, 0); step(0);
      drive(0, 1, 1, 1);   // changes while busy must not matter
      for (int i = 0; i < 6; i++) begin
         if (i > 0) step(0);
         chk("b_r_pulse", 1, r_w[1], i < 3);
         chk("b_s_zero", 1, s_w[1], 1'b0);
         chk("b_ready", 1, rdy_w[1], i == 5);
         chk("b_q", 1, q_w[1], i < 3);
      end

      // ---- u_c (P=4, G=0): reset in second pulse cycle ----
      drive(1, 0, 0, 0); step(0);
      drive(0, 1, 1, 0); step(0);
      chk("c_s_first", 2, s_w[2], 1'b1);
      drive(0, 0, 0, 0); step(0);
      chk("c_s_second", 2, s_w[2], 1'b1);
      drive(1, 0, 0, 0); step(0);
      chk("c_s_reset", 2, s_w[2], 1'b0);
      chk("c_q_reset", 2, q_w[2], 1'b0);
      drive(0, 0, 0, 0); step(0);
      chk("c_ready_after", 2, rdy_w[2], 1'b1);
      chk("c_q_after", 2, q_w[2], 1'b0);

`ifdef SR_CTRL_CHECK_EN
      // ---- readback error on u_a with q_i tied low ----
      q_tie = 1'b1;
      drive(1, 0, 0, 0); step(0);
      drive(0, 1, 1, 0); step(0);
      drive(0, 0, 0, 0); step(0);
      chk("a_err_not_yet", 0, err_w[0], 1'b0);
      step(0);
      chk("a_err_set", 0, err_w[0], 1'b1);
      step(0); step(0);
      chk("a_err_sticky", 0, err_w[0], 1'b1);
      clr = 1'b1; step(0); clr = 1'b0;
      chk("a_err_cleared", 0, err_w[0], 1'b0);
      q_tie = 1'b0;
`endif

      // ---- randomized traffic ----
      drive(1, 0, 0, 0); step(0);
      for (int i = 0; i < 10000; i++) begin
         rst   = ($urandom_range(0, 199) == 0);
         valid = ($urandom_range(0, 3) != 0);
         level = 1'($urandom_range(0, 1));
         frc   = ($urandom_range(0, 5) == 0);
         clr   = ($urandom_range(0, 15) == 0);
         step($urandom_range(0, 7) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule : tb_sr_ctrl
`default_nettype wire
